i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit bus address this slave answers to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of input synchronizer flops on scl and sda (minimum 2).
REQ-003 Port list, one port per line (name  direction  width  meaning):
  clk  input  1  system clock; the only clock.
  rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
  scl  input  1  I2C serial clock, asynchronous to clk.
  sda  inout  1  I2C data; the slave drives only 0 or z (open-drain); the bus pull-up is external.
  host_we  input  1  host-side register write strobe.
  host_waddr  input  4  host write index.
  host_wdata  input  8  host write data.
  host_raddr  input  4  host read index.
  host_rdata  output  8  combinational reg[host_raddr].
  busy  output  1  high from START detect until STOP detect.
  bus_wr_pulse  output  1  one-clk pulse when a bus data byte is written into the register file.
  bus_wr_idx  output  4  index written; valid while bus_wr_pulse is high.
  ptr  output  4  current register pointer.

Function
REQ-004 Register file: 16 x 8 bits, clocked by clk; pointer arithmetic SHALL be modulo 16 (index 15+1 -> 0); only ptr[3:0] of the received pointer byte SHALL be used.
REQ-005 scl and sda SHALL each pass through SYNC_STAGES flops; edge detection SHALL compare the last synchronized value with the previous one.
REQ-006 START SHALL be a synced sda 1->0 transition while synced scl = 1; STOP SHALL be a synced sda 0->1 transition while synced scl = 1.
REQ-007 A START in any state, including a repeated START, SHALL go to ADDR, clear the bit counter and set busy.
REQ-008 A STOP in any state SHALL go to IDLE, clear busy and release sda; a partially received byte SHALL be discarded.
REQ-009 Received bits SHALL be sampled on the synced scl rising edge, MSB first; the bit counter SHALL run 0..7.
REQ-010 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
REQ-011 ADDR: after 8 bits, the block SHALL compare byte[7:1] with SLAVE_ADDR. On a match it SHALL go to ADDR_ACK. On a mismatch it SHALL go to IGNORE and leave sda undriven.
REQ-012 ACK drive: on the synced scl falling edge that ends bit 8, the block SHALL drive sda = 0, hold it through the next scl high period, and release it on the following synced scl falling edge.
REQ-013 After ADDR_ACK: if R/W = 0, the next state SHALL be PTR. If R/W = 1, the next state SHALL be RDATA, and the shift register SHALL load reg[ptr] at the ACK-release falling edge.
REQ-014 PTR: 8 bits -> ptr <= byte[3:0] -> PTR_ACK (ACK per REQ-012) -> WDATA.
REQ-015 WDATA: 8 bits -> reg[ptr] <= byte, bus_wr_pulse = 1 for one clk with bus_wr_idx = ptr, ptr <= ptr+1 -> WDATA_ACK (ACK) -> WDATA.
REQ-016 RDATA: at each synced scl falling edge, the block SHALL drive sda = 0 for a 0 bit and z for a 1 bit, MSB first. After the 8th bit's falling edge it SHALL release sda and go to RDATA_MACK.
REQ-017 RDATA_MACK: the block SHALL sample sda on the scl rising edge. If sda = 0 (ACK): ptr <= ptr+1, reg[ptr+1] is loaded at the next falling edge, and the state returns to RDATA. If sda = 1 (NACK): go to IGNORE.
REQ-018 IGNORE SHALL never drive sda and SHALL exit only on START or STOP.
REQ-019 Simultaneous host_we and bus write to the same index in the same clk: the host write SHALL win; bus_wr_pulse SHALL still assert.
REQ-020 A host write to reg[ptr] during RDATA SHALL NOT alter the byte already being shifted out.
REQ-021 ptr SHALL persist across transactions; only a PTR byte or auto-increment SHALL change it.

Reset
REQ-022 While rst = 0 at a clk edge, the block SHALL apply: state = IDLE, sda = z, busy = 0, bus_wr_pulse = 0, bus_wr_idx = 0, ptr = 0, all 16 registers = 8'h00, synchronizer flops = 1, bit counter = 0.
REQ-023 Reset asserted mid-transaction SHALL take effect in that same clk. After release, the block SHALL ignore bus activity until the next START.

Verification
REQ-024 Host write reg[3] = 8'hA5; the existing I2C read master with DeviceAddr = 7'h50, RegisterAddr = 8'h03 -> master ReadData = 8'hA5 and ReadDoneFlag = 1; both ACKs are driven low.
REQ-025 START, 8'hA0, 8'h0E, 8'h11, 8'h22, 8'h33, STOP -> reg[14] = 8'h11, reg[15] = 8'h22, reg[0] = 8'h33, three bus_wr_pulse with idx 14, 15, 0; final ptr = 1.
REQ-026 START, 8'hA2 (address 7'h51) -> sda stays high at the ACK bit, no register changes, block stays in IGNORE until STOP.
REQ-027 With reg[5..7] = 8'h01, 8'h02, 8'h03 and ptr set to 5, read with master ACK, ACK, NACK -> bytes 8'h01, 8'h02, 8'h03 returned; final ptr = 7.
REQ-028 STOP after 4 bits of a WDATA byte -> no write, busy = 0, state = IDLE; rst = 0 during RDATA -> sda released within 1 clk and all registers read 8'h00.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a 16 x 8 register file: pointer byte after the address, then
// auto-incrementing writes or reads. Host side gets a direct write port and a read mux.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic       host_we,
  input  logic [3:0] host_waddr,
  input  logic [7:0] host_wdata,
  input  logic [3:0] host_raddr,
  output logic [7:0] host_rdata,
  output logic       busy,
  output logic       bus_wr_pulse,
  output logic [3:0] bus_wr_idx,
  output logic [3:0] ptr
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_PTR        = 4'd3,
    ST_PTR_ACK    = 4'd4,
    ST_WDATA      = 4'd5,
    ST_WDATA_ACK  = 4'd6,
    ST_RDATA      = 4'd7,
    ST_RDATA_MACK = 4'd8,
    ST_IGNORE     = 4'd9
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_prev_r, sda_prev_r;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic [3:0] ptr_r, ptr_nxt_s;
  logic       sda_oe_r, oe_nxt_s;
  logic       ack_flag_r, ack_flag_nxt_s;
  logic       rw_r, rw_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       wr_pulse_r;
  logic [3:0] wr_idx_r;
  logic       bus_we_s;
  logic [7:0] byte_s, rd_byte_s;
  logic [7:0] regs_r [16];

  // Bring scl/sda into the clk domain and keep the previous synced value for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & ~sda_prev_r & sda_s;
  assign byte_s     = {shift_r[6:0], sda_s};
  assign rd_byte_s  = regs_r[ptr_r];

  // Next-state and datapath decode; bus START/STOP override whatever the FSM is doing
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shift_nxt_s    = shift_r;
    ptr_nxt_s      = ptr_r;
    oe_nxt_s       = sda_oe_r;
    ack_flag_nxt_s = ack_flag_r;
    rw_nxt_s       = rw_r;
    busy_nxt_s     = busy_r;
    bus_we_s       = 1'b0;
    if (start_s) begin
      state_nxt_s    = ST_ADDR;
      cnt_nxt_s      = 3'd0;
      busy_nxt_s     = 1'b1;
      oe_nxt_s       = 1'b0;
      ack_flag_nxt_s = 1'b0;
    end else if (stop_s) begin
      state_nxt_s    = ST_IDLE;
      cnt_nxt_s      = 3'd0;
      busy_nxt_s     = 1'b0;
      oe_nxt_s       = 1'b0;
      ack_flag_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_nxt_s = byte_s;
            if (cnt_r == 3'd7) begin
              cnt_nxt_s      = 3'd0;
              ack_flag_nxt_s = 1'b0;
              if (state_r == ST_ADDR) begin
                if (byte_s[7:1] == SLAVE_ADDR) begin
                  rw_nxt_s    = byte_s[0];
                  state_nxt_s = ST_ADDR_ACK;
                end else begin
                  state_nxt_s = ST_IGNORE;
                end
              end else if (state_r == ST_PTR) begin
                ptr_nxt_s   = byte_s[3:0];
                state_nxt_s = ST_PTR_ACK;
              end else begin
                bus_we_s    = 1'b1;
                ptr_nxt_s   = ptr_r + 4'd1;
                state_nxt_s = ST_WDATA_ACK;
              end
            end else begin
              cnt_nxt_s = cnt_r + 3'd1;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First falling edge pulls sda low, the second one releases it and moves on
          if (scl_fall_s) begin
            if (!ack_flag_r) begin
              oe_nxt_s       = 1'b1;
              ack_flag_nxt_s = 1'b1;
            end else begin
              oe_nxt_s       = 1'b0;
              ack_flag_nxt_s = 1'b0;
              cnt_nxt_s      = 3'd0;
              if (state_r == ST_ADDR_ACK && rw_r) begin
                state_nxt_s = ST_RDATA;
                shift_nxt_s = rd_byte_s;
                oe_nxt_s    = ~rd_byte_s[7];
              end else if (state_r == ST_ADDR_ACK) begin
                state_nxt_s = ST_PTR;
              end else begin
                state_nxt_s = ST_WDATA;
              end
            end
          end else begin
            oe_nxt_s = sda_oe_r;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s) begin
            if (cnt_r == 3'd7) begin
              oe_nxt_s       = 1'b0;
              cnt_nxt_s      = 3'd0;
              ack_flag_nxt_s = 1'b0;
              state_nxt_s    = ST_RDATA_MACK;
            end else begin
              cnt_nxt_s   = cnt_r + 3'd1;
              shift_nxt_s = {shift_r[6:0], shift_r[7]};
              oe_nxt_s    = ~shift_r[6];
            end
          end else begin
            oe_nxt_s = sda_oe_r;
          end
        end
        ST_RDATA_MACK: begin
          if (scl_rise_s) begin
            if (!sda_s) begin
              ptr_nxt_s      = ptr_r + 4'd1;
              ack_flag_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_IGNORE;
            end
          end else if (scl_fall_s && ack_flag_r) begin
            ack_flag_nxt_s = 1'b0;
            cnt_nxt_s      = 3'd0;
            shift_nxt_s    = rd_byte_s;
            oe_nxt_s       = ~rd_byte_s[7];
            state_nxt_s    = ST_RDATA;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          oe_nxt_s    = 1'b0;
        end
      endcase
    end
  end

  // Control/datapath registers and the register file; a host write beats a bus write to the same index
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      shift_r    <= 8'h00;
      ptr_r      <= 4'd0;
      sda_oe_r   <= 1'b0;
      ack_flag_r <= 1'b0;
      rw_r       <= 1'b0;
      busy_r     <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_idx_r   <= 4'd0;
      for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      ptr_r      <= ptr_nxt_s;
      sda_oe_r   <= oe_nxt_s;
      ack_flag_r <= ack_flag_nxt_s;
      rw_r       <= rw_nxt_s;
      busy_r     <= busy_nxt_s;
      wr_pulse_r <= bus_we_s;
      wr_idx_r   <= bus_we_s ? ptr_r : wr_idx_r;
      for (int i = 0; i < 16; i++) begin
        if (host_we && host_waddr == 4'(i)) regs_r[i] <= host_wdata;
        else if (bus_we_s && ptr_r == 4'(i)) regs_r[i] <= byte_s;
        else regs_r[i] <= regs_r[i];
      end
    end
  end

  assign sda          = sda_oe_r ? 1'b0 : 1'bz;
  assign host_rdata   = regs_r[host_raddr];
  assign busy         = busy_r;
  assign bus_wr_pulse = wr_pulse_r;
  assign bus_wr_idx   = wr_idx_r;
  assign ptr          = ptr_r;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master plus host-port pokes against i2c_slave_regfile.
module tb_i2c_slave_regfile;

  localparam int Q = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       host_we = 1'b0;
  logic [3:0] host_waddr = 4'd0;
  logic [7:0] host_wdata = 8'h00;
  logic [3:0] host_raddr = 4'd0;
  logic [7:0] host_rdata;
  logic       busy, bus_wr_pulse;
  logic [3:0] bus_wr_idx, ptr;

  int checks = 0;
  int errors = 0;
  int wr_q[$];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .busy(busy), .bus_wr_pulse(bus_wr_pulse), .bus_wr_idx(bus_wr_idx), .ptr(ptr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_wr_pulse === 1'b1) wr_q.push_back(int'(bus_wr_idx));

  task automatic hwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_waddr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    host_raddr = a;
    #1 d = host_rdata;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; hwait(Q);
    scl = 1'b1;   hwait(Q);
    m_low = 1'b1; hwait(Q);
    scl = 1'b0;   hwait(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; hwait(Q);
    scl = 1'b1;   hwait(Q);
    m_low = 1'b0; hwait(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; hwait(Q);
    scl = 1'b1; hwait(2*Q);
    scl = 1'b0; hwait(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; hwait(Q);
    scl = 1'b1;   hwait(Q);
    b = sda;      hwait(Q);
    scl = 1'b0;   hwait(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
    m_low = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0;
    hwait(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr); end
    checks++; if (bus_wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", bus_wr_pulse); end
    checks++; if (bus_wr_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus_wr_idx); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h exp 00", i, d); end
    end
    rst = 1'b1;
    hwait(4);
  endtask

  task automatic test_read_reg3();
    logic a;
    logic [7:0] d;
    host_write(4'd3, 8'hA5);
    i2c_start();
    write_byte(8'hA0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL r3_addr_ack got %b exp 0", a); end
    write_byte(8'h03, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL r3_ptr_ack got %b exp 0", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL r3_busy got %b exp 1", busy); end
    i2c_start();
    write_byte(8'hA1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL r3_raddr_ack got %b exp 0", a); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL r3_data got %h exp a5", d); end
    i2c_stop();
    hwait(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL r3_idle got %b exp 0", busy); end
    checks++; if (ptr !== 4'd3) begin errors++; $display("FAIL r3_ptr got %0d exp 3", ptr); end
  endtask

  task automatic test_write_wrap();
    logic a;
    logic [7:0] d;
    logic [7:0] seq [5] = '{8'hA0, 8'h0E, 8'h11, 8'h22, 8'h33};
    int exp_idx [3] = '{14, 15, 0};
    int got;
    wr_q.delete();
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(seq[i], a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack%0d got %b exp 0", i, a); end
    end
    i2c_stop();
    hwait(4);
    peek(4'd14, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_reg14 got %h exp 11", d); end
    peek(4'd15, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_reg15 got %h exp 22", d); end
    peek(4'd0, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL wrap_reg0 got %h exp 33", d); end
    checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL wrap_pulses got %0d exp 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : -1;
      checks++; if (got != exp_idx[i]) begin errors++; $display("FAIL wrap_idx%0d got %0d exp %0d", i, got, exp_idx[i]); end
    end
    checks++; if (ptr !== 4'd1) begin errors++; $display("FAIL wrap_ptr got %0d exp 1", ptr); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    logic [7:0] d;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA2, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nak_addr got %b exp 1", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nak_busy got %b exp 1", busy); end
    write_byte(8'h05, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nak_byte1 got %b exp 1", a); end
    write_byte(8'h77, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nak_byte2 got %b exp 1", a); end
    i2c_stop();
    hwait(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nak_idle got %b exp 0", busy); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL nak_pulses got %0d exp 0", wr_q.size()); end
    checks++; if (ptr !== 4'd1) begin errors++; $display("FAIL nak_ptr got %0d exp 1", ptr); end
    peek(4'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL nak_reg5 got %h exp 00", d); end
  endtask

  task automatic test_partial_stop();
    logic a;
    logic [7:0] d;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL part_addr_ack got %b exp 0", a); end
    write_byte(8'h08, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL part_ptr_ack got %b exp 0", a); end
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    hwait(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL part_busy got %b exp 0", busy); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL part_pulses got %0d exp 0", wr_q.size()); end
    checks++; if (ptr !== 4'd8) begin errors++; $display("FAIL part_ptr got %0d exp 8", ptr); end
    peek(4'd8, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL part_reg8 got %h exp 00", d); end
  endtask

  task automatic test_host_collision();
    logic a;
    logic [7:0] d;
    logic [7:0] v = 8'h5A;
    int got;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h09, a);
    for (int i = 7; i >= 1; i--) write_bit(v[i]);
    m_low = ~v[0]; hwait(Q);
    host_waddr = 4'd9; host_wdata = 8'hC3; host_we = 1'b1;
    scl = 1'b1; hwait(2*Q);
    host_we = 1'b0;
    scl = 1'b0; hwait(Q);
    read_bit(a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL coll_ack got %b exp 0", a); end
    i2c_stop();
    hwait(4);
    peek(4'd9, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL coll_reg9 got %h exp c3", d); end
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL coll_pulses got %0d exp 1", wr_q.size()); end
    got = (wr_q.size() > 0) ? wr_q[0] : -1;
    checks++; if (got != 9) begin errors++; $display("FAIL coll_idx got %0d exp 9", got); end
    checks++; if (ptr !== 4'd10) begin errors++; $display("FAIL coll_ptr got %0d exp 10", ptr); end
  endtask

  task automatic test_read_seq();
    logic a;
    logic [7:0] d;
    host_write(4'd5, 8'h01);
    host_write(4'd6, 8'h02);
    host_write(4'd7, 8'h03);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h05, a);
    i2c_start();
    write_byte(8'hA1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL seq_addr_ack got %b exp 0", a); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL seq_b0 got %h exp 01", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL seq_b1 got %h exp 02", d); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL seq_b2 got %h exp 03", d); end
    i2c_stop();
    hwait(4);
    checks++; if (ptr !== 4'd7) begin errors++; $display("FAIL seq_ptr got %0d exp 7", ptr); end
  endtask

  task automatic test_host_during_read();
    logic a;
    logic [7:0] d;
    host_write(4'd2, 8'h3C);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    i2c_start();
    write_byte(8'hA1, a);
    host_write(4'd2, 8'hFF);
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL hrd_data got %h exp 3c", d); end
    i2c_stop();
    hwait(4);
    peek(4'd2, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL hrd_reg2 got %h exp ff", d); end
    checks++; if (ptr !== 4'd2) begin errors++; $display("FAIL hrd_ptr got %0d exp 2", ptr); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic [7:0] d;
    host_write(4'd0, 8'h33);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h00, a);
    i2c_start();
    write_byte(8'hA1, a);
    hwait(2);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL mrst_drive got %b exp 0", sda); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL mrst_release got %b exp 1", sda); end
    hwait(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy); end
    checks++; if (ptr !== 4'd0) begin errors++; $display("FAIL mrst_ptr got %0d exp 0", ptr); end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL mrst_reg%0d got %h exp 00", i, d); end
    end
    rst = 1'b1;
    hwait(4);
    i2c_stop();
    scl = 1'b0; hwait(Q);
    write_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL mrst_nostart got %b exp 1", a); end
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mrst_addr_ack got %b exp 0", a); end
    write_byte(8'h04, a);
    write_byte(8'h77, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mrst_data_ack got %b exp 0", a); end
    i2c_stop();
    hwait(4);
    peek(4'd4, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL mrst_reg4 got %h exp 77", d); end
  endtask

  initial begin
    test_reset();
    test_read_reg3();
    test_write_wrap();
    test_wrong_addr();
    test_partial_stop();
    test_host_collision();
    test_read_seq();
    test_host_during_read();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
